fc_bias_sequencer: RTL



---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_sat_add.sv | 36 +++
 rtl/fc_bias_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared constants, types and sequencer states for the fc2 bias sequencer.
package fc_pkg;

  localparam int FC2_NUM_NEURONS = 16;
  localparam int FC_ACC_W        = 32;
  localparam int FC_BIAS_W       = 32;

  typedef logic signed [FC_ACC_W-1:0] fc_acc_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } fc_seq_state_e;

endpackage

// File: rtl/fc_sat_add.sv
// Combinational signed accumulator + bias add, clamped to the output range.
// Optional macro FC_BIAS_RELU_EN: zero out negative results after saturation.
module fc_sat_add #(
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 32,
  parameter int OUT_W  = 32
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [OUT_W-1:0]  sum
);

  // One guard bit is enough: overflow shows up as disagreement of the top two bits.
  function automatic logic signed [OUT_W-1:0] sat_add(input logic signed [ACC_W-1:0]  a,
                                                     input logic signed [BIAS_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = s[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      sat_add = s[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] x);
`ifdef FC_BIAS_RELU_EN
    relu = x[OUT_W-1] ? '0 : x;
`else
    relu = x;
`endif
  endfunction

  always_comb begin
    sum = relu(sat_add(acc, bias));
  end

endmodule

// File: rtl/fc_bias_sequencer.sv
// Adds per-neuron fc2 biases to an accumulator vector and streams one neuron per beat.
// Optional macro FC_BIAS_RELU_EN (in fc_sat_add) clamps negative results to zero.
module fc_bias_sequencer
  import fc_pkg::*;
#(
  parameter int NUM_NEURONS = FC2_NUM_NEURONS,
  parameter int ACC_W       = FC_ACC_W,
  parameter int BIAS_W      = FC_BIAS_W,
  parameter int OUT_W       = FC_ACC_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_NEURONS*BIAS_W-1:0]   bias_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*ACC_W-1:0]    in_acc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         out_data,
  output logic [$clog2(NUM_NEURONS)-1:0]  out_idx,
  output logic                            out_last,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  fc_seq_state_e                  state;
  logic [NUM_NEURONS*ACC_W-1:0]   acc_p0;
  logic [NUM_NEURONS*ACC_W-1:0]   src_acc;
  logic [IDX_W-1:0]               ld_idx;
  logic signed [ACC_W-1:0]        ld_acc;
  logic signed [BIAS_W-1:0]       ld_bias;
  logic signed [OUT_W-1:0]        ld_sum;
  logic                           accept;
  logic                           advance;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign advance  = out_valid && out_ready;

  // Beat 0 is built straight from the incoming vector so it can appear one cycle after accept.
  always_comb begin
    ld_idx  = (state == IDLE) ? '0 : out_idx + 1'b1;
    src_acc = (state == IDLE) ? in_acc : acc_p0;
    ld_acc  = src_acc[ld_idx*ACC_W +: ACC_W];
    ld_bias = bias_data[ld_idx*BIAS_W +: BIAS_W];
  end

  fc_sat_add #(
    .ACC_W  (ACC_W),
    .BIAS_W (BIAS_W),
    .OUT_W  (OUT_W)
  ) u_sat_add (
    .acc  (ld_acc),
    .bias (ld_bias),
    .sum  (ld_sum)
  );

  // Stage p0: captured accumulator vector, held for the whole stream
  always_ff @(posedge clk) begin
    if (accept) acc_p0 <= in_acc;
  end

  // Stage p1: sequencer state and the registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_data  <= ld_sum;
            out_idx   <= '0;
            out_last  <= (NUM_NEURONS == 1);
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (advance) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= DRAIN;
            end else begin
              out_data  <= ld_sum;
              out_idx   <= ld_idx;
              out_last  <= (ld_idx == LAST_IDX);
            end
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
